// File: rtl/warp_lsu.sv
// Load-store unit for one warp: serialises the active lanes of one LDR/STR,
// lowest lane first, onto a single data-memory read port and write port.
module warp_lsu #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            mem_read_en,
    input  logic                            mem_write_en,
    input  logic [NUM_LANES-1:0]            lane_mask,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] rs1,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0]           imm,
    input  logic                            release_warp,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [NUM_LANES*DATA_WIDTH-1:0] lsu_out,
    output logic                            mem_read_valid,
    output logic [ADDR_WIDTH-1:0]           mem_read_address,
    input  logic                            mem_read_ready,
    input  logic [DATA_WIDTH-1:0]           mem_read_data,
    output logic                            mem_write_valid,
    output logic [ADDR_WIDTH-1:0]           mem_write_address,
    output logic [DATA_WIDTH-1:0]           mem_write_data,
    input  logic                            mem_write_ready
);

    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]                      state_q;
    logic [NUM_LANES-1:0]            pending_q;
    logic                            is_read_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] rs1_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] rs2_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] lsu_out_q;
    logic [DATA_WIDTH-1:0]           imm_q;
    logic [DATA_WIDTH-1:0]           wdata_q;
    logic [LANE_W-1:0]               lane_q;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic                            rd_valid_q;
    logic                            wr_valid_q;
    logic                            err_q;
    logic                            busy_q;
    logic                            done_q;

    logic [LANE_W-1:0]               first_lane;
    logic [DATA_WIDTH-1:0]           first_base;
    logic [ADDR_WIDTH-1:0]           first_addr;
    logic                            ready;

    // Scan downwards so the lowest pending lane wins.
    always_comb begin
        first_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending_q[i]) first_lane = LANE_W'(i);
        end
    end

    assign first_base = rs1_q[int'(first_lane)*DATA_WIDTH +: DATA_WIDTH];
    assign first_addr = ADDR_WIDTH'(first_base + imm_q);
    assign ready      = is_read_q ? mem_read_ready : mem_write_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            is_read_q  <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            lsu_out_q  <= '0;
            imm_q      <= '0;
            wdata_q    <= '0;
            lane_q     <= '0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        rs1_q     <= rs1;
                        rs2_q     <= rs2;
                        imm_q     <= imm;
                        pending_q <= lane_mask;
                        // Both enables set resolves to a read and flags err.
                        is_read_q <= mem_read_en;
                        err_q     <= mem_read_en & mem_write_en;
                        busy_q    <= 1'b1;
                        if (mem_read_en || mem_write_en) begin
                            state_q <= StIssue;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (pending_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        lane_q     <= first_lane;
                        addr_q     <= first_addr;
                        wdata_q    <= rs2_q[int'(first_lane)*DATA_WIDTH +: DATA_WIDTH];
                        rd_valid_q <= is_read_q;
                        wr_valid_q <= ~is_read_q;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (ready) begin
                        rd_valid_q <= 1'b0;
                        wr_valid_q <= 1'b0;
                        if (is_read_q) begin
                            lsu_out_q[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] <= mem_read_data;
                        end
                        pending_q[lane_q] <= 1'b0;
                        state_q           <= StIssue;
                    end
                end
                StDone: begin
                    if (release_warp) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign lsu_out           = lsu_out_q;
    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = addr_q;
    assign mem_write_data    = wdata_q;

endmodule

// File: tb/tb_warp_lsu.sv
// Bench for warp_lsu: directed and random warp operations against a memory
// and lane-result model derived from the lane mask, addresses and latency rules.
module tb_warp_lsu;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [NL-1:0]     lane_mask;
    logic [NL*DW-1:0]  rs1;
    logic [NL*DW-1:0]  rs2;
    logic [DW-1:0]     imm;
    logic              release_warp;
    logic              busy;
    logic              done;
    logic              err;
    logic [NL*DW-1:0]  lsu_out;
    logic              mem_read_valid;
    logic [AW-1:0]     mem_read_address;
    logic              mem_read_ready;
    logic [DW-1:0]     mem_read_data;
    logic              mem_write_valid;
    logic [AW-1:0]     mem_write_address;
    logic [DW-1:0]     mem_write_data;
    logic              mem_write_ready;

    warp_lsu #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .mem_read_en       (mem_read_en),
        .mem_write_en      (mem_write_en),
        .lane_mask         (lane_mask),
        .rs1               (rs1),
        .rs2               (rs2),
        .imm               (imm),
        .release_warp      (release_warp),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .lsu_out           (lsu_out),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] model_out [NL];

    task automatic check(input string tag, input logic [NL*DW-1:0] obs,
                         input logic [NL*DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NL*DW-1:0] model_packed();
        logic [NL*DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = model_out[i];
        return r;
    endfunction

    function automatic logic [NL*DW-1:0] rand_wide();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {busy, done, err, mem_read_valid, mem_write_valid}, '0);
        check({tag, "_lsu"}, lsu_out, '0);
        check({tag, "_addr"}, {mem_read_address, mem_write_address, mem_write_data}, '0);
    endtask

    // One full operation: start, serve memory with random ready delays, check
    // every request against the expected lane order, then release.
    task automatic do_op(input logic rd, input logic wr, input logic [NL-1:0] mask,
                         input logic [NL*DW-1:0] r1, input logic [NL*DW-1:0] r2,
                         input logic [DW-1:0] im, input int dmin, input int dmax,
                         input bit abort);
        int            exp_lane[$];
        logic [AW-1:0] exp_addr[$];
        int            n = 0;
        int            cyc = 0;
        int            wait_cnt = 0;
        int            dly;
        int            hold;
        bit            seen_done = 0;
        logic          is_rd = rd;
        logic [AW-1:0] obs_addr;

        for (int i = 0; i < NL; i++) begin
            if (mask[i] && (rd || wr)) begin
                exp_lane.push_back(i);
                exp_addr.push_back(AW'(r1[i*DW +: DW] + im));
                n++;
            end
        end

        @(posedge clk); #1;
        mem_read_en = rd; mem_write_en = wr; lane_mask = mask;
        rs1 = r1; rs2 = r2; imm = im; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Operands must have been latched: scramble them from here on.
        rs1 = rand_wide(); rs2 = rand_wide(); imm = $urandom; lane_mask = NL'($urandom);
        dly = $urandom_range(dmax, dmin);

        while (!seen_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            check("err", err, (cyc == 1 && rd && wr));
            check("busy", busy, 1);
            if (done) begin
                seen_done = 1;
            end else if (mem_read_valid || mem_write_valid) begin
                wait_cnt++;
                check("valid_kind", {mem_read_valid, mem_write_valid}, is_rd ? 2'b10 : 2'b01);
                check("access_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() == 0) begin
                    mem_read_ready = 1'b1; mem_write_ready = 1'b1;
                end else begin
                    obs_addr = is_rd ? mem_read_address : mem_write_address;
                    check("addr", obs_addr, exp_addr[0]);
                    if (!is_rd) check("wdata", mem_write_data, r2[exp_lane[0]*DW +: DW]);
                    if (abort) begin
                        start = 1'b0; reset = 1'b1;
                        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
                        @(negedge clk);
                        check_all_zero("abort");
                        reset = 1'b0;
                        for (int i = 0; i < NL; i++) model_out[i] = '0;
                        return;
                    end
                    if (wait_cnt > dly) begin
                        if (is_rd) begin
                            mem_read_data = mem[exp_addr[0]];
                            model_out[exp_lane[0]] = mem[exp_addr[0]];
                            mem_read_ready = 1'b1; mem_write_ready = 1'($urandom);
                        end else begin
                            mem[exp_addr[0]] = r2[exp_lane[0]*DW +: DW];
                            mem_write_ready = 1'b1; mem_read_ready = 1'($urandom);
                            mem_read_data = $urandom;
                        end
                        void'(exp_addr.pop_front());
                        void'(exp_lane.pop_front());
                        wait_cnt = 0;
                        dly = $urandom_range(dmax, dmin);
                    end else if (is_rd) begin
                        mem_read_ready = 1'b0; mem_write_ready = 1'($urandom);
                    end else begin
                        mem_write_ready = 1'b0; mem_read_ready = 1'($urandom);
                    end
                end
            end else begin
                // No request outstanding: ready noise must be ignored.
                mem_read_ready = 1'($urandom); mem_write_ready = 1'($urandom);
                mem_read_data = $urandom;
            end
            if (!seen_done) begin
                start = ($urandom_range(3, 0) == 0);
                mem_read_en = 1'($urandom); mem_write_en = 1'($urandom);
            end
        end

        start = 1'b0; mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        check("done_seen", seen_done, 1);
        if (dmax == 0) check("latency", cyc, (rd || wr) ? 2 + 2 * n : 1);
        check("accesses_left", exp_addr.size(), 0);
        check("lsu_out", lsu_out, model_packed());

        hold = $urandom_range(2, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("done_hold", {busy, done}, 2'b11);
        end
        release_warp = 1'b1;
        @(negedge clk);
        release_warp = 1'b0;
        check("released", {busy, done, mem_read_valid, mem_write_valid}, '0);
    endtask

    initial begin
        logic [NL*DW-1:0] w;
        logic             rd;
        logic             wr;

        reset = 1'b1; start = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
        lane_mask = '0; rs1 = '0; rs2 = '0; imm = '0; release_warp = 1'b0;
        mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < NL; i++) model_out[i] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Fill every lane so the masked-off lane below has a visible old value.
        do_op(1'b1, 1'b0, 4'hF, rand_wide(), rand_wide(), $urandom, 0, 0, 0);
        // Reads at 4, 14, 34; lane 2 untouched; done 8 cycles after start.
        do_op(1'b1, 1'b0, 4'b1011, {32'd30, 32'd20, 32'd10, 32'd0}, rand_wide(), 32'd4,
              0, 0, 0);
        // Single store, ready three cycles late.
        w = '0; w[DW-1:0] = 32'd7;
        do_op(1'b0, 1'b1, 4'b0001, w, {96'h0, 32'h0000_DEAD}, 32'd0, 3, 3, 0);
        // Read back the stored word.
        do_op(1'b1, 1'b0, 4'b0001, w, rand_wide(), 32'd0, 0, 0, 0);
        check("store_readback", lsu_out[DW-1:0], 32'h0000_DEAD);
        // Empty mask, then no operation at all.
        do_op(1'b1, 1'b0, 4'b0000, rand_wide(), rand_wide(), $urandom, 0, 0, 0);
        do_op(1'b0, 1'b0, 4'hF, rand_wide(), rand_wide(), $urandom, 0, 0, 0);
        // Address wraps modulo 2^32, then truncates to 8'h01.
        w = rand_wide(); w[DW-1:0] = 32'hFFFF_FFFF;
        do_op(1'b1, 1'b0, 4'b0001, w, rand_wide(), 32'd2, 0, 0, 0);
        // Both enables: err pulse, performed as a read.
        do_op(1'b1, 1'b1, 4'b0110, rand_wide(), rand_wide(), $urandom, 0, 1, 0);
        // Reset while a read is waiting, then a fresh operation.
        do_op(1'b1, 1'b0, 4'hF, rand_wide(), rand_wide(), $urandom, 2, 2, 1);
        do_op(1'b1, 1'b0, 4'b1100, rand_wide(), rand_wide(), $urandom, 0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            do_op(rd, wr, NL'($urandom), rand_wide(), rand_wide(), $urandom,
                  0, (t % 3 == 0) ? 0 : 3, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
